sb_stall_unit: RTL

Scoreboard-based interlock for the pipelined MIPS core, sitting beside the decode stage and driving the fetch/decode hold signal. It replaces fixed stage-by-stage register compares with a per-register countdown scoreboard. This supports variable producer latencies (ALU, load, multi-cycle ops), a forwarding or no-forwarding mode, write-after-write protection, and a saturating stall-cycle counter for performance monitoring.

---
 rtl/sb_stall_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/sb_stall_unit.sv
// Decode-stage interlock: per-register countdown scoreboard that holds fetch/decode
// until every source is forwardable (or written back) and no older write would land later.
module sb_stall_unit #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int CW      = 3,
    parameter int FWD_EN  = 1,
    parameter int WB_DIST = 2,
    parameter int SCW     = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            id_valid_i,
    input  logic [AW-1:0]   id_rs_i,
    input  logic [AW-1:0]   id_rt_i,
    input  logic            id_use_rs_i,
    input  logic            id_use_rt_i,
    input  logic            id_we_i,
    input  logic [AW-1:0]   id_wd_i,
    input  logic [CW-1:0]   id_lat_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [NREG-1:0] pend_vec_o,
    output logic [SCW-1:0]  stall_cnt_o
);

    localparam int MAXI = (1 << CW) - 1;

    logic [CW-1:0]  cnt_w [NREG];
    logic [CW-1:0]  lv;
    logic           raw_rs, raw_rt, waw, issue;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

    generate
        if (FWD_EN != 0) begin : g_fwd
            assign lv = id_lat_i;
        end else begin : g_nofwd
            // One spare bit catches overflow so the load value saturates instead of wrapping
            localparam int WBC = (WB_DIST > MAXI) ? MAXI : WB_DIST;
            logic [CW:0] lv_sum;
            assign lv_sum = {1'b0, id_lat_i} + (CW+1)'(WBC);
            assign lv     = lv_sum[CW] ? CW'(MAXI) : lv_sum[CW-1:0];
        end
    endgenerate

    assign raw_rs  = id_use_rs_i & (cnt_w[id_rs_i] != '0);
    assign raw_rt  = id_use_rt_i & (cnt_w[id_rt_i] != '0);
    assign waw     = id_we_i & (id_wd_i != '0) & (cnt_w[id_wd_i] > lv);
    assign stall_o = id_valid_i & ~flush_i & (raw_rs | raw_rt | waw);
    assign issue   = id_valid_i & ~flush_i & ~stall_o;

    generate
        for (genvar r = 0; r < NREG; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign cnt_w[r]      = '0;
                assign pend_vec_o[r] = 1'b0;
            end else begin : g_cnt
                logic [CW-1:0] cnt_q, cnt_d;

                // A fresh producer load wins over the countdown of the same register
                always_comb begin
                    cnt_d = cnt_q;
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    if (issue && id_we_i && (id_wd_i == AW'(r)) && (lv != '0)) cnt_d = lv;
                end

                always_ff @(posedge clk_i or negedge rst_n_i) begin
                    if (!rst_n_i) cnt_q <= '0;
                    else          cnt_q <= cnt_d;
                end

                assign cnt_w[r]      = cnt_q;
                assign pend_vec_o[r] = (cnt_q != '0);
            end
        end
    endgenerate

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
